// File: rtl/sqrt2.sv
// sqrt2: IEEE-754 binary16 square root on a shared bidirectional bus, using a bit-serial restoring root.
// Build macro SQRT2_RNE_EN: compute two guard bits plus sticky and round to nearest-even (default truncates).
module sqrt2 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    inout  wire  [15:0] IO_DATA,
    output logic        RESULT,
    output logic        IS_NAN,
    output logic        IS_PINF,
    output logic        IS_NINF
);
`ifdef SQRT2_RNE_EN
    localparam int NB  = 13;
    localparam int RMW = NB + 1;
`else
    localparam int NB  = 11;
    localparam int RMW = NB;
`endif
    localparam int         RW   = 2 * NB;
    localparam logic [3:0] LAST = 4'd13;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {C_NUM = 2'd0, C_ZERO = 2'd1, C_NAN = 2'd2, C_PINF = 2'd3} cls_t;

    state_t            state_r, next_state_s;
    cls_t              cls_s, cls_r;
    logic              sign_r, capture_s, fits_s;
    logic [4:0]        exp_r, res_exp_s, exp_out_s;
    logic [3:0]        cnt_r, msb_s;
    logic [RW-1:0]     rad_r, rad_s;
    logic [NB-1:0]     root_r;
    logic [RMW-1:0]    rem_r;
    logic [NB+1:0]     rem_try_s, trial_s, rem_sub_s;
    logic [10:0]       sig11_s;
    logic [11:0]       sig12_s;
    logic signed [6:0] e_s, e_adj_s, half_s;
    logic [9:0]        frac_out_s;
    logic [15:0]       done_data_s, nxt_data_s, data_r;
    logic              done_nan_s, done_pinf_s;
    logic              nxt_result_s, nxt_nan_s, nxt_pinf_s;
    logic              result_r, nan_r, pinf_r;

    assign capture_s = (state_r == IDLE) && ENABLE;

    // Classify and unpack the operand straight off the bus so the radicand is ready at capture.
    always_comb begin
        msb_s = 4'd0;
        for (int i = 0; i < 10; i++) begin
            msb_s = IO_DATA[i] ? 4'(i) : msb_s;
        end
        if (IO_DATA[14:10] == 5'h1F) begin
            cls_s = (IO_DATA[9:0] == 10'd0 && !IO_DATA[15]) ? C_PINF : C_NAN;
        end else if (IO_DATA[14:0] == 15'd0) begin
            cls_s = C_ZERO;
        end else if (IO_DATA[15]) begin
            cls_s = C_NAN;
        end else begin
            cls_s = C_NUM;
        end
        if (IO_DATA[14:10] == 5'd0) begin
            sig11_s = 11'({1'b0, IO_DATA[9:0]} << (4'd10 - msb_s));
            e_s     = $signed({3'b000, msb_s}) - 7'sd24;
        end else begin
            sig11_s = {1'b1, IO_DATA[9:0]};
            e_s     = $signed({2'b00, IO_DATA[14:10]}) - 7'sd15;
        end
        if (e_s[0]) begin
            sig12_s = {sig11_s, 1'b0};
            e_adj_s = e_s - 7'sd1;
        end else begin
            sig12_s = {1'b0, sig11_s};
            e_adj_s = e_s;
        end
        half_s    = (e_adj_s >>> 1) + 7'sd15;
        res_exp_s = half_s[4:0];
        rad_s     = {sig12_s, {(RW - 12){1'b0}}};
    end

    // One restoring-root step: bring down two radicand bits and try subtracting 4*root+1.
    always_comb begin
        rem_try_s = {rem_r[NB-1:0], rad_r[RW-1:RW-2]};
        trial_s   = {root_r, 2'b01};
        rem_sub_s = rem_try_s - trial_s;
        fits_s    = (rem_try_s >= trial_s);
    end

    // Datapath: load at capture, then iterate one root bit per CALC cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cls_r  <= C_ZERO;
            sign_r <= 1'b0;
            exp_r  <= 5'd0;
            cnt_r  <= 4'd0;
            rad_r  <= {RW{1'b0}};
            root_r <= {NB{1'b0}};
            rem_r  <= {RMW{1'b0}};
        end else if (capture_s) begin
            cls_r  <= cls_s;
            sign_r <= IO_DATA[15];
            exp_r  <= res_exp_s;
            cnt_r  <= 4'd0;
            rad_r  <= rad_s;
            root_r <= {NB{1'b0}};
            rem_r  <= {RMW{1'b0}};
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r + 4'd1;
            if (cnt_r < 4'(NB)) begin
                rad_r  <= {rad_r[RW-3:0], 2'b00};
                root_r <= {root_r[NB-2:0], fits_s};
                rem_r  <= fits_s ? RMW'(rem_sub_s) : RMW'(rem_try_s);
            end
        end
    end

`ifdef SQRT2_RNE_EN
    logic [10:0] rnd_sum_s;
    logic        rnd_up_s;

    // Nearest-even rounding; an 11-bit wrap to below 1.0 means the fraction carried into the exponent.
    always_comb begin
        rnd_up_s  = root_r[1] & (root_r[0] | (rem_r != {RMW{1'b0}}) | root_r[2]);
        rnd_sum_s = root_r[12:2] + {10'd0, rnd_up_s};
        if (!rnd_sum_s[10]) begin
            frac_out_s = 10'd0;
            exp_out_s  = exp_r + 5'd1;
        end else begin
            frac_out_s = rnd_sum_s[9:0];
            exp_out_s  = exp_r;
        end
    end
`else
    // Truncating result: drop the implicit leading one.
    always_comb begin
        frac_out_s = root_r[9:0];
        exp_out_s  = exp_r;
    end
`endif

    // Final result word and flags for the latched operand class.
    always_comb begin
        done_nan_s  = 1'b0;
        done_pinf_s = 1'b0;
        case (cls_r)
            C_PINF: begin
                done_data_s = 16'h7C00;
                done_pinf_s = 1'b1;
            end
            C_NAN: begin
                done_data_s = 16'hFE00;
                done_nan_s  = 1'b1;
            end
            C_ZERO:  done_data_s = {sign_r, 15'd0};
            default: done_data_s = {1'b0, exp_out_s, frac_out_s};
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; dropping ENABLE during CALC aborts.
    always_comb begin
        case (state_r)
            IDLE:    next_state_s = ENABLE ? CALC : IDLE;
            CALC:    next_state_s = !ENABLE ? IDLE : ((cnt_r == LAST) ? DONE : CALC);
            DONE:    next_state_s = ENABLE ? DONE : IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: outputs are valid exactly while the FSM sits in DONE.
    always_comb begin
        if (next_state_s == DONE) begin
            nxt_result_s = 1'b1;
            nxt_data_s   = done_data_s;
            nxt_nan_s    = done_nan_s;
            nxt_pinf_s   = done_pinf_s;
        end else begin
            nxt_result_s = 1'b0;
            nxt_data_s   = 16'h0000;
            nxt_nan_s    = 1'b0;
            nxt_pinf_s   = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            result_r <= 1'b0;
            data_r   <= 16'h0000;
            nan_r    <= 1'b0;
            pinf_r   <= 1'b0;
        end else begin
            result_r <= nxt_result_s;
            data_r   <= nxt_data_s;
            nan_r    <= nxt_nan_s;
            pinf_r   <= nxt_pinf_s;
        end
    end

    assign IO_DATA = result_r ? data_r : 16'bz;
    assign RESULT  = result_r;
    assign IS_NAN  = nan_r;
    assign IS_PINF = pinf_r;
    assign IS_NINF = 1'b0;
endmodule

// File: tb/tb_sqrt2.sv
// Directed bench for sqrt2: vector table of binary16 roots plus protocol, abort and reset sequences.
module tb_sqrt2;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        drv_en;
    logic [15:0] drv_val;
    wire  [15:0] io_data;
    logic        result, is_nan, is_pinf, is_ninf;
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        logic [2:0]  flg;   // {nan, pinf, ninf}
    } vec_t;

    vec_t vecs[$];

    assign io_data = drv_en ? drv_val : 16'bz;

    sqrt2 dut (
        .CLK(clk), .RST(rst), .ENABLE(enable), .IO_DATA(io_data),
        .RESULT(result), .IS_NAN(is_nan), .IS_PINF(is_pinf), .IS_NINF(is_ninf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] op, input logic [15:0] res, input logic [2:0] flg);
        vec_t v;
        v.op  = op;
        v.res = res;
        v.flg = flg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus, RESULT and flags all quiet: the bench drives 0000 and must read it back unchanged.
    task automatic check_quiet(input string name);
        drv_en  = 1'b1;
        drv_val = 16'h0000;
        #1;
        check(name, {result, io_data, is_nan, is_pinf, is_ninf}, 32'h0);
        drv_en = 1'b0;
    endtask

    // Capture at edge C, host drives through C+1, then bench watches quiet bus through C+13.
    task automatic launch(input logic [15:0] a, input string name);
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        drv_en  = 1'b1;
        drv_val = a;
        enable  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1 drv_val = 16'h0000;
            #1 bad = bad | result | is_nan | is_pinf | is_ninf | (io_data !== 16'h0000);
        end
        drv_en = 1'b0;
        check({name, "_latency"}, {31'd0, bad}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name, input int hold);
        logic bad;
        logic [19:0] exp_out;
        launch(v.op, name);
        exp_out = {1'b1, v.res, v.flg};
        @(posedge clk);
        #1 check({name, "_out"}, {12'd0, result, io_data, is_nan, is_pinf, is_ninf}, {12'd0, exp_out});
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1 bad = bad | ({result, io_data, is_nan, is_pinf, is_ninf} !== exp_out);
        end
        if (hold > 0) check({name, "_hold"}, {31'd0, bad}, 32'd0);
        enable = 1'b0;
        @(posedge clk);
        #1 check_quiet({name, "_release"});
    endtask

    initial begin
        logic bad;
        rst     = 1'b1;
        enable  = 1'b0;
        drv_en  = 1'b0;
        drv_val = 16'h0000;

        vecs.push_back(mk(16'h7C00, 16'h7C00, 3'b010));
        vecs.push_back(mk(16'hFC00, 16'hFE00, 3'b100));
        vecs.push_back(mk(16'h7E00, 16'hFE00, 3'b100));
        vecs.push_back(mk(16'h7D00, 16'hFE00, 3'b100));
        vecs.push_back(mk(16'hBC00, 16'hFE00, 3'b100));
        vecs.push_back(mk(16'hC400, 16'hFE00, 3'b100));
        vecs.push_back(mk(16'hB800, 16'hFE00, 3'b100));
        vecs.push_back(mk(16'h8001, 16'hFE00, 3'b100));
        vecs.push_back(mk(16'h0000, 16'h0000, 3'b000));
        vecs.push_back(mk(16'h8000, 16'h8000, 3'b000));
        vecs.push_back(mk(16'h3C00, 16'h3C00, 3'b000));
        vecs.push_back(mk(16'h4400, 16'h4000, 3'b000));
        vecs.push_back(mk(16'h4880, 16'h4200, 3'b000));
        vecs.push_back(mk(16'h5640, 16'h4900, 3'b000));
        vecs.push_back(mk(16'h3400, 16'h3800, 3'b000));
        vecs.push_back(mk(16'h4000, 16'h3DA8, 3'b000));
        vecs.push_back(mk(16'h2800, 16'h31A8, 3'b000));
        vecs.push_back(mk(16'h6400, 16'h5000, 3'b000));
        vecs.push_back(mk(16'h4200, 16'h3EED, 3'b000));
        vecs.push_back(mk(16'h4500, 16'h4078, 3'b000));
        vecs.push_back(mk(16'h4B80, 16'h43BE, 3'b000));
        vecs.push_back(mk(16'h2E66, 16'h350F, 3'b000));
        vecs.push_back(mk(16'h3A00, 16'h3AED, 3'b000));
        vecs.push_back(mk(16'h63E8, 16'h4FF3, 3'b000));
        vecs.push_back(mk(16'h70E2, 16'h5640, 3'b000));
        vecs.push_back(mk(16'h7BFF, 16'h5BFF, 3'b000));
        vecs.push_back(mk(16'h0001, 16'h0C00, 3'b000));
        vecs.push_back(mk(16'h0002, 16'h0DA8, 3'b000));
        vecs.push_back(mk(16'h0040, 16'h1800, 3'b000));
        vecs.push_back(mk(16'h03FF, 16'h1FFE, 3'b000));
        vecs.push_back(mk(16'h0400, 16'h2000, 3'b000));
        vecs.push_back(mk(16'h0800, 16'h21A8, 3'b000));

        repeat (3) @(posedge clk);
        #1 check_quiet("reset_state");
        rst = 1'b0;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d_%h", i, vecs[i].op), (i % 8 == 0) ? 4 : 0);
        end

        // Abort: ENABLE dropped mid-CALC, no result may ever appear.
        @(negedge clk);
        drv_en  = 1'b1;
        drv_val = 16'h4400;
        enable  = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 drv_val = 16'h0000;
        enable = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 bad = bad | result | is_nan | is_pinf | (io_data !== 16'h0000);
        end
        drv_en = 1'b0;
        check("abort_no_result", {31'd0, bad}, 32'd0);
        run_vec(mk(16'h4400, 16'h4000, 3'b000), "after_abort", 0);

        // Reset asserted mid-CALC.
        @(negedge clk);
        drv_en  = 1'b1;
        drv_val = 16'h4000;
        enable  = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1 drv_val = 16'h0000;
        rst = 1'b1;
        @(posedge clk);
        #1 check_quiet("reset_mid_calc");
        rst    = 1'b0;
        enable = 1'b0;
        bad    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1 bad = bad | result;
        end
        check("reset_mid_calc_stays_idle", {31'd0, bad}, 32'd0);
        run_vec(mk(16'h4000, 16'h3DA8, 3'b000), "after_reset_calc", 0);

        // Reset asserted in DONE while ENABLE is still high.
        launch(16'hFC00, "reset_done");
        @(posedge clk);
        #1 check("reset_done_valid", {12'd0, result, io_data, is_nan, is_pinf, is_ninf},
                 {12'd0, 1'b1, 16'hFE00, 3'b100});
        rst = 1'b1;
        @(posedge clk);
        #1 check_quiet("reset_in_done");
        rst    = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        run_vec(mk(16'h5640, 16'h4900, 3'b000), "after_reset_done", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sqrt2.md
# sqrt2

IEEE-754 binary16 square-root unit with a shared bidirectional data bus. The host drives an operand onto `IO_DATA` while raising `ENABLE`. The block computes the root with a bit-serial integer square root, then drives the result back onto the same bus with classification flags. It sits as a memory-mapped style coprocessor on a shared 16-bit data bus.

## Interface
- No parameters.
- `CLK` in 1: clock; all state updates on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ENABLE` in 1: request; starts a capture from IDLE; holding it high keeps the result presented.
- `IO_DATA` inout 16: binary16 operand in, result out. High-Z except while `RESULT`=1.
- `RESULT` out 1: result valid and bus driven.
- `IS_NAN` out 1: result is NaN.
- `IS_PINF` out 1: result is +inf.
- `IS_NINF` out 1: result is −inf; never asserted by sqrt, tied low in effect.

## Operation
- States: IDLE → CALC → DONE.
- **IDLE:** At an edge with `ENABLE`=1, latch `IO_DATA` and go to CALC.
- **CALC:** Fixed-length computation, then go to DONE.
- **DONE:**
  - Drive `IO_DATA` with the result and hold `RESULT`=1 plus the flags.
  - At an edge with `ENABLE`=0, return to IDLE: release the bus and clear `RESULT` and all flags.
- **Abort:** `ENABLE`=0 at any edge in CALC aborts to IDLE with no result.
- **Special cases** (checked on the latched operand, same latency as normal operands):
  - +inf (7C00) → 7C00, `IS_PINF`=1.
  - Any NaN (exp=1F, frac≠0, quiet or signalling, either sign) → FE00, `IS_NAN`=1.
  - −inf → FE00, `IS_NAN`=1.
  - Any negative nonzero, including negative subnormals → FE00, `IS_NAN`=1.
  - +0 → 0000; −0 → 8000; no flags.
- **Finite positive operands:**
  - Unpack the operand.
  - Normalise subnormals by leading-zero count, giving an unbiased exponent e and an 11-bit significand with implicit 1.
  - If e is odd: shift the significand left 1 and decrement e.
  - Result exponent = e/2 + 15.
  - Take the integer square root of the significand shifted into a 22-bit radicand; this yields an 11-bit root of the form 1.xxxxxxxxxx.
  - Rounding is toward zero (truncate).
  - The result is always normal (range 0C00..5BFF); overflow and underflow are impossible.
- Output flags are 0 whenever `RESULT`=0.

## Timing
- **Reset:** In reset, state=IDLE, `RESULT`=0, all flags 0, `IO_DATA` high-Z. Reset overrides `ENABLE` in any state.
- **Capture edge C:** the first rising edge in IDLE with `ENABLE`=1. The operand is sampled at C.
- **Host drive window:** The host may keep driving through edge C+1. The block must not drive the bus before edge C+14.
- **Latency:** `RESULT`, the flags, and bus drive become valid after edge C+14 (fixed 14 cycles, identical for special values). They remain stable while `ENABLE`=1.
- **Release:** The bus is released, and `RESULT` drops, after the first edge with `ENABLE`=0 in DONE.
- **Restart:** A new request needs at least one IDLE edge with `ENABLE`=0 before it. `ENABLE` held high continuously never restarts a computation.

## Configuration
- `SQRT2_RNE_EN`:
  - When defined, the root is computed with 2 extra guard bits plus a sticky bit (nonzero remainder) and rounded to nearest-even.
  - A carry out of the fraction increments the exponent.
  - Latency stays 14 cycles.
  - Example: 4200 → 3EEE.
- Undefined (default build): truncation as specified above. All test values below assume the default.

## Test plan
- **Specials:**
  - 7C00 → 7C00 with `IS_PINF`.
  - FC00, 7E00, 7D00, BC00, C400, B800 → FE00 with `IS_NAN`.
  - 0000 → 0000 and 8000 → 8000 with no flags.
- **Exact roots and powers of two:**
  - 3C00→3C00, 4400→4000, 4880→4200, 5640→4900, 3400→3800.
  - 4000→3DA8, 2800→31A8, 6400→5000.
- **Truncation:**
  - 4200→3EED, 4500→4078, 4B80→43BE, 2E66→350F, 3A00→3AED.
  - 63E8→4FF3, 70E2→5640, 7BFF→5BFF.
- **Subnormals:**
  - 0001→0C00, 0002→0DA8, 0040→1800, 03FF→1FFE.
  - 0400→2000, 0800→21A8.
- **Protocol:**
  - `RESULT` first high after edge C+14.
  - `IO_DATA` is Z through C+13; no contention while the host drives through C+1.
  - `ENABLE` low → bus Z and `RESULT` 0 next edge.
  - `ENABLE` dropped in CALC aborts with no `RESULT`.
- **Reset:**
  - `RST` asserted mid-CALC and in DONE → next edge: bus Z, `RESULT` and all flags 0.
  - The next request completes normally.
